// File: rtl/evt_counter_pkg.sv
// Shared types and helpers for the multi-channel event counter bank.
package evt_counter_pkg;

    typedef enum logic {
        SNAP_IDLE   = 1'b0,
        SNAP_STREAM = 1'b1
    } snap_state_t;

    // Channel-index width, never narrower than one bit.
    function automatic int ch_idx_w(input int num_ch);
        return (num_ch > 2) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/evt_counter_ch.sv
// One modulo up/down event counter with load, clear and a registered terminal-count pulse.
module evt_counter_ch #(
    parameter int WIDTH     = 27,
    parameter int MAX_COUNT = 134217728,
    parameter int SATURATE  = 0
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             clr_in,
    input  logic             load_in,
    input  logic             evt_in,
    input  logic             dir_in,
    input  logic [WIDTH-1:0] load_val_in,
    output logic [WIDTH-1:0] count_out,
    output logic             tc_out
);

    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MAX_COUNT - 1);
    localparam bit               SAT   = (SATURATE != 0);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (clr_in) begin
            count_d = '0;
        end else if (load_in) begin
            count_d = (load_val_in > LIMIT) ? LIMIT : load_val_in;
        end else if (evt_in) begin
            if (!dir_in) begin
                if (count_q == LIMIT) begin
                    tc_d    = 1'b1;
                    count_d = SAT ? LIMIT : '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                // Underflow mirrors overflow: wrap to the top or stick at zero.
                if (count_q == '0) begin
                    tc_d    = 1'b1;
                    count_d = SAT ? '0 : LIMIT;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count_out = count_q;
    assign tc_out    = tc_q;

endmodule

// File: rtl/evt_counter_bank.sv
// Bank of NUM_CH event counters with an atomic snapshot streamed out one channel per handshake.
module evt_counter_bank
    import evt_counter_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int WIDTH     = 27,
    parameter int MAX_COUNT = 134217728,
    parameter int SATURATE  = 0
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          clr_in,
    input  logic [NUM_CH-1:0]             evt_in,
    input  logic [NUM_CH-1:0]             dir_in,
    input  logic                          load_in,
    input  logic [ch_idx_w(NUM_CH)-1:0]   load_ch_in,
    input  logic [WIDTH-1:0]              load_val_in,
    output logic [NUM_CH*WIDTH-1:0]       count_out,
    output logic [NUM_CH-1:0]             tc_out,
    input  logic                          snap_in,
    output logic                          snap_valid_out,
    input  logic                          snap_ready_in,
    output logic [ch_idx_w(NUM_CH)-1:0]   snap_ch_out,
    output logic [WIDTH-1:0]              snap_data_out,
    output logic                          snap_busy_out,
    output logic                          snap_overrun_out,
    output snap_state_t                   snap_state_out
);

    localparam int                CH_W     = ch_idx_w(NUM_CH);
    localparam logic [CH_W-1:0]   LAST_IDX = CH_W'(NUM_CH - 1);

    logic [WIDTH-1:0] cnt [NUM_CH];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        evt_counter_ch #(
            .WIDTH     (WIDTH),
            .MAX_COUNT (MAX_COUNT),
            .SATURATE  (SATURATE)
        ) u_ch (
            .clk_in      (clk_in),
            .rst_n_in    (rst_n_in),
            .clr_in      (clr_in),
            .load_in     (load_in && (load_ch_in == CH_W'(i))),
            .evt_in      (evt_in[i]),
            .dir_in      (dir_in[i]),
            .load_val_in (load_val_in),
            .count_out   (cnt[i]),
            .tc_out      (tc_out[i])
        );
        assign count_out[i*WIDTH +: WIDTH] = cnt[i];
    end

    snap_state_t      state_q, state_d;
    logic [CH_W-1:0]  idx_q, idx_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] shadow_q [NUM_CH];
    logic [WIDTH-1:0] shadow_d [NUM_CH];

    // Stream handshake: a word transfers in any cycle where snap_valid_out and
    // snap_ready_in are both high; while valid is high and ready is low the
    // word (snap_ch_out, snap_data_out) holds, and valid never drops before
    // its transfer except through reset.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        shadow_d  = shadow_q;
        if (clr_in) begin
            overrun_d = 1'b0;
        end
        case (state_q)
            SNAP_IDLE: begin
                if (snap_in) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        shadow_d[i] = cnt[i];
                    end
                    idx_d   = '0;
                    state_d = SNAP_STREAM;
                end
            end
            SNAP_STREAM: begin
                if (snap_in) begin
                    overrun_d = 1'b1;
                end
                if (snap_ready_in) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = SNAP_IDLE;
                    end else begin
                        idx_d = idx_q + CH_W'(1);
                    end
                end
            end
            default: state_d = SNAP_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= SNAP_IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
            shadow_q  <= '{default: '0};
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
            shadow_q  <= shadow_d;
        end
    end

    assign snap_valid_out   = (state_q == SNAP_STREAM);
    assign snap_busy_out    = (state_q == SNAP_STREAM);
    assign snap_ch_out      = idx_q;
    assign snap_data_out    = shadow_q[idx_q];
    assign snap_overrun_out = overrun_q;
    assign snap_state_out   = state_q;

endmodule

// File: tb/tb_evt_counter_bank.sv
// Bench for evt_counter_bank: a wrapping and a saturating instance driven in lockstep and compared to a reference model.
module tb_evt_counter_bank;
    import evt_counter_pkg::*;

    localparam int NCH = 4;
    localparam int W   = 5;
    localparam int MC  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           clr, load, snap, ready;
    logic [NCH-1:0] evt, dir;
    logic [1:0]     load_ch;
    logic [W-1:0]   load_val;

    logic [NCH*W-1:0] cnt_w, cnt_s;
    logic [NCH-1:0]   tc_w, tc_s;
    logic             sv_w, sv_s, sb_w, sb_s, so_w, so_s;
    logic [1:0]       sch_w, sch_s;
    logic [W-1:0]     sd_w, sd_s;
    snap_state_t      st_w, st_s;

    evt_counter_bank #(.NUM_CH(NCH), .WIDTH(W), .MAX_COUNT(MC), .SATURATE(0)) dut_w (
        .clk_in(clk), .rst_n_in(rst_n), .clr_in(clr), .evt_in(evt), .dir_in(dir),
        .load_in(load), .load_ch_in(load_ch), .load_val_in(load_val),
        .count_out(cnt_w), .tc_out(tc_w), .snap_in(snap), .snap_valid_out(sv_w),
        .snap_ready_in(ready), .snap_ch_out(sch_w), .snap_data_out(sd_w),
        .snap_busy_out(sb_w), .snap_overrun_out(so_w), .snap_state_out(st_w)
    );

    evt_counter_bank #(.NUM_CH(NCH), .WIDTH(W), .MAX_COUNT(MC), .SATURATE(1)) dut_s (
        .clk_in(clk), .rst_n_in(rst_n), .clr_in(clr), .evt_in(evt), .dir_in(dir),
        .load_in(load), .load_ch_in(load_ch), .load_val_in(load_val),
        .count_out(cnt_s), .tc_out(tc_s), .snap_in(snap), .snap_valid_out(sv_s),
        .snap_ready_in(ready), .snap_ch_out(sch_s), .snap_data_out(sd_s),
        .snap_busy_out(sb_s), .snap_overrun_out(so_s), .snap_state_out(st_s)
    );

    // Reference model: index 0 = wrap instance, 1 = saturate instance.
    int             m_cnt [2][NCH];
    logic [NCH-1:0] m_tc  [2];
    logic           m_ov;
    // Pending snapshot words: {ch[1:0], wrap data, saturate data}.
    logic [11:0]    exp_q[$];
    logic [11:0]    dut_log[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            m_tc[m] = '0;
            for (int i = 0; i < NCH; i++) m_cnt[m][i] = 0;
        end
        m_ov = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_step();
        bit busy;
        int c;
        busy = (exp_q.size() != 0);
        if (busy) begin
            if (ready) void'(exp_q.pop_front());
        end else if (snap) begin
            for (int i = 0; i < NCH; i++)
                exp_q.push_back({2'(i), 5'(m_cnt[0][i]), 5'(m_cnt[1][i])});
        end
        if (snap && busy) m_ov = 1'b1;
        else if (clr)     m_ov = 1'b0;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < NCH; i++) begin
                c = m_cnt[m][i];
                m_tc[m][i] = 1'b0;
                if (clr) begin
                    c = 0;
                end else if (load && int'(load_ch) == i) begin
                    c = (int'(load_val) > MC - 1) ? MC - 1 : int'(load_val);
                end else if (evt[i] && !dir[i]) begin
                    m_tc[m][i] = (c == MC - 1);
                    if (m == 0)          c = (c + 1) % MC;
                    else if (c < MC - 1) c = c + 1;
                end else if (evt[i] && dir[i]) begin
                    m_tc[m][i] = (c == 0);
                    if (m == 0)     c = (c + MC - 1) % MC;
                    else if (c > 0) c = c - 1;
                end
                m_cnt[m][i] = c;
            end
        end
    endtask

    task automatic compare_all();
        logic [11:0] f;
        bit busy;
        busy = (exp_q.size() != 0);
        for (int i = 0; i < NCH; i++) begin
            check($sformatf("cnt_w[%0d]", i), 32'(cnt_w[i*W +: W]), 32'(m_cnt[0][i]));
            check($sformatf("cnt_s[%0d]", i), 32'(cnt_s[i*W +: W]), 32'(m_cnt[1][i]));
        end
        check("tc_w", 32'(tc_w), 32'(m_tc[0]));
        check("tc_s", 32'(tc_s), 32'(m_tc[1]));
        check("valid", 32'({sv_w, sv_s}), busy ? 32'd3 : 32'd0);
        check("busy", 32'({sb_w, sb_s}), busy ? 32'd3 : 32'd0);
        check("overrun", 32'({so_w, so_s}), m_ov ? 32'd3 : 32'd0);
        check("state", 32'(st_w), busy ? 32'(SNAP_STREAM) : 32'(SNAP_IDLE));
        if (busy) begin
            f = exp_q[0];
            check("snap_ch", 32'({sch_w, sch_s}), 32'({f[11:10], f[11:10]}));
            check("snap_data_w", 32'(sd_w), 32'(f[9:5]));
            check("snap_data_s", 32'(sd_s), 32'(f[4:0]));
        end
    endtask

    task automatic cycle();
        if (sv_w && ready) dut_log.push_back({sch_w, sd_w, sd_s});
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_idle();
        clr = 0; load = 0; snap = 0; ready = 0;
        evt = '0; dir = '0; load_ch = '0; load_val = '0;
    endtask

    typedef struct {
        logic           clr;
        logic [NCH-1:0] evt;
        logic [NCH-1:0] dir;
        logic           load;
        logic [1:0]     ld_ch;
        logic [W-1:0]   ld_val;
        int             ch;
        logic [W-1:0]   cw;
        logic           tw;
        logic [W-1:0]   cs;
        logic           ts;
    } vec_t;

    function automatic vec_t mk(logic c, logic [3:0] e, logic [3:0] d, logic l, logic [1:0] lc,
                                logic [4:0] lv, int ch, logic [4:0] cw, logic tw,
                                logic [4:0] cs, logic ts);
        vec_t v;
        v.clr = c; v.evt = e; v.dir = d; v.load = l; v.ld_ch = lc; v.ld_val = lv;
        v.ch = ch; v.cw = cw; v.tw = tw; v.cs = cs; v.ts = ts;
        return v;
    endfunction

    vec_t vt [16];
    int   snap_vals [NCH] = '{5, 6, 7, 3};
    int   rdy_pat [6]     = '{1, 0, 1, 1, 0, 1};
    logic [11:0] exp_words [NCH] = '{12'h0A5, 12'h4C6, 12'h8E7, 12'hC63};

    initial begin
        set_idle();
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        check("rst_snap_data", 32'({sd_w, sd_s}), 32'd0);
        check("rst_snap_ch", 32'({sch_w, sch_s}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Wrap up on ch0: 9 events; saturating twin sticks at 7.
        for (int k = 0; k < 9; k++)
            vt[k] = mk(0, 4'b0001, 4'b0000, 0, 2'd0, 5'd0, 0,
                       5'((k + 1) % MC), k == 7, 5'((k < 7) ? k + 1 : 7), k >= 7);
        vt[9]  = mk(0, 4'b0000, 4'b0000, 1, 2'd1, 5'd2, 1, 5'd2, 0, 5'd2, 0);
        vt[10] = mk(0, 4'b0010, 4'b0010, 0, 2'd0, 5'd0, 1, 5'd1, 0, 5'd1, 0);
        vt[11] = mk(0, 4'b0010, 4'b0010, 0, 2'd0, 5'd0, 1, 5'd0, 0, 5'd0, 0);
        vt[12] = mk(0, 4'b0010, 4'b0010, 0, 2'd0, 5'd0, 1, 5'd7, 1, 5'd0, 1);
        vt[13] = mk(0, 4'b0010, 4'b0010, 0, 2'd0, 5'd0, 1, 5'd6, 0, 5'd0, 1);
        vt[14] = mk(0, 4'b0100, 4'b0000, 1, 2'd2, 5'd20, 2, 5'd7, 0, 5'd7, 0);
        vt[15] = mk(1, 4'b1111, 4'b0000, 1, 2'd2, 5'd3, 2, 5'd0, 0, 5'd0, 0);

        for (int k = 0; k < 16; k++) begin
            clr = vt[k].clr; evt = vt[k].evt; dir = vt[k].dir;
            load = vt[k].load; load_ch = vt[k].ld_ch; load_val = vt[k].ld_val;
            cycle();
            check($sformatf("tbl%0d_cnt_w", k), 32'(cnt_w[vt[k].ch*W +: W]), 32'(vt[k].cw));
            check($sformatf("tbl%0d_tc_w", k), 32'(tc_w[vt[k].ch]), 32'(vt[k].tw));
            check($sformatf("tbl%0d_cnt_s", k), 32'(cnt_s[vt[k].ch*W +: W]), 32'(vt[k].cs));
            check($sformatf("tbl%0d_tc_s", k), 32'(tc_s[vt[k].ch]), 32'(vt[k].ts));
        end

        // Snapshot of {5,6,7,3} with ch0 still counting and ready backpressure.
        set_idle();
        for (int i = 0; i < NCH; i++) begin
            load = 1; load_ch = 2'(i); load_val = 5'(snap_vals[i]);
            cycle();
        end
        set_idle();
        dut_log.delete();
        snap = 1; evt = 4'b0001;
        cycle();
        snap = 0;
        for (int k = 0; k < 6; k++) begin
            ready = rdy_pat[k][0];
            cycle();
        end
        ready = 0; evt = '0;
        cycle();
        check("snap_busy_end", 32'(sb_w), 32'd0);
        check("snap_word_count", 32'(dut_log.size()), 32'(NCH));
        for (int i = 0; i < NCH && i < dut_log.size(); i++)
            check($sformatf("snap_word%0d", i), 32'(dut_log[i]), 32'(exp_words[i]));

        // Overrun set, cleared by clr, and set winning over a simultaneous clr.
        set_idle();
        snap = 1; cycle();
        snap = 0; cycle();
        snap = 1; cycle();
        check("ovr_set", 32'(so_w), 32'd1);
        snap = 0; clr = 1; cycle();
        check("ovr_clr", 32'(so_w), 32'd0);
        snap = 1; clr = 1; cycle();
        check("ovr_set_wins", 32'(so_w), 32'd1);
        set_idle();
        ready = 1;
        repeat (NCH) cycle();
        ready = 0; cycle();

        // Asynchronous reset after two words have gone out.
        set_idle();
        load = 1; load_ch = 2'd3; load_val = 5'd5; cycle();
        set_idle();
        snap = 1; cycle();
        snap = 0; ready = 1;
        repeat (2) cycle();
        ready = 0;
        check("pre_rst_ch", 32'(sch_w), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("async_rst_valid", 32'({sv_w, sb_w}), 32'd0);
        #1 rst_n = 1'b1;
        snap = 1; cycle();
        check("post_rst_ch", 32'(sch_w), 32'd0);
        check("post_rst_valid", 32'(sv_w), 32'd1);
        snap = 0; ready = 1;
        repeat (NCH) cycle();

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            evt      = 4'($urandom_range(0, 15));
            dir      = 4'($urandom_range(0, 15));
            load     = ($urandom_range(0, 9) == 0);
            load_ch  = 2'($urandom_range(0, 3));
            load_val = 5'($urandom_range(0, 31));
            clr      = ($urandom_range(0, 29) == 0);
            snap     = ($urandom_range(0, 7) == 0);
            ready    = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/evt_counter_bank.md
Name: evt_counter_bank

Overview:
Parametrised multi-channel event counter bank; the successor to the single-channel modulo event counter. Each channel counts up or down modulo a programmable limit, with selectable wrap or saturate mode, synchronous load, and a one-cycle terminal-count pulse. A snapshot engine atomically captures all channels and streams them out over a valid/ready interface. It is used for display-timing, encoder and debug event statistics.

Parameters:
NUM_CH, 4, number of independent channels (1..16)
WIDTH, 27, counter width in bits per channel
MAX_COUNT, 134217728, modulus; legal counts 0..MAX_COUNT-1; must satisfy 2 <= MAX_COUNT <= 2**WIDTH
SATURATE, 0, 0 = wrap at limits, 1 = hold at limits

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  asynchronous active-low reset
clr_in  input  1  synchronous clear of all counters and the overrun flag
evt_in  input  NUM_CH  per-channel count event, one count per cycle high
dir_in  input  NUM_CH  per-channel direction, 0 = up, 1 = down
load_in  input  1  synchronous load strobe
load_ch_in  input  $clog2(NUM_CH) (min 1)  channel selected for load
load_val_in  input  WIDTH  load value
count_out  output  NUM_CH*WIDTH  live counts; channel i at bits [i*WIDTH +: WIDTH]
tc_out  output  NUM_CH  one-cycle terminal-count pulse per channel
snap_in  input  1  snapshot request pulse
snap_valid_out  output  1  snapshot word valid
snap_ready_in  input  1  consumer ready
snap_ch_out  output  $clog2(NUM_CH) (min 1)  channel index of the current word
snap_data_out  output  WIDTH  captured count of that channel
snap_busy_out  output  1  stream in progress
snap_overrun_out  output  1  sticky: snap_in arrived while busy

Behaviour:
- Reset (rst_n_in low, asynchronous): all counts 0, tc_out 0, FSM IDLE, snap_valid_out 0, snap_busy_out 0, snap_ch_out 0, snap_data_out 0, snap_overrun_out 0. Reset mid-stream aborts the stream.
- Per-channel update priority per cycle: clr_in > load (load_in and load_ch_in == i) > evt_in. Only one action applies.
- Load: count <= load_val_in; if load_val_in >= MAX_COUNT, clamp to MAX_COUNT-1. No tc pulse. load_ch_in >= NUM_CH is ignored.
- Up event: if count < MAX_COUNT-1, then count+1. At MAX_COUNT-1: wrap mode goes to 0 with a tc pulse; saturate mode holds with a tc pulse.
- Down event: if count > 0, then count-1. At 0: wrap mode goes to MAX_COUNT-1 with a tc pulse; saturate mode holds at 0 with a tc pulse.
- tc_out is registered and high in the cycle after the event, alongside the new count. It is high in every cycle in which a limit event occurs.
- Arithmetic is WIDTH bits. The comparisons use MAX_COUNT-1 truncated to WIDTH, which is legal by the parameter constraint.
- Snapshot FSM, states IDLE and STREAM:
  - IDLE + snap_in: shadow[i] <= the count_out register values in that cycle (pre-update), index <= 0, go to STREAM. From the next cycle, snap_valid_out and snap_busy_out are 1.
  - STREAM: snap_data_out = shadow[index] and snap_ch_out = index. These stay stable while valid && !ready.
  - Handshake valid && ready: if index == NUM_CH-1, go to IDLE (valid and busy drop next cycle). Otherwise index + 1.
  - snap_in while in STREAM, including the final-handshake cycle: ignored, and snap_overrun_out is set.
  - clr_in does not abort a stream (the shadow is already captured). It clears snap_overrun_out; a simultaneous new overrun wins (set).
- Counting continues unaffected during streaming.

Decomposition:
- evt_counter_pkg:
  - snap_state_t enum {SNAP_IDLE, SNAP_STREAM}
  - localparam-style function ch_idx_w(NUM_CH) returning max(1, $clog2(NUM_CH))
- Sub-module evt_counter_ch: one channel (count register, limit logic, tc), instantiated NUM_CH times via generate.
- Snapshot FSM and shadow registers live in the top level.

Test Plan:
- Wrap up, MAX_COUNT=8, SATURATE=0, ch0 up: 9 events from 0 → counts 1..7,0,1; tc_out[0] high only in the cycle count shows 0.
- Saturate down, SATURATE=1, ch1 loaded with 2, down, 4 events → 1,0,0,0; tc_out[1] high on the last two events only.
- Load priority, MAX_COUNT=8: load_in with ch2, value 20, plus evt_in[2] in the same cycle → count 7, no tc. Then clr_in with load_in → all counts 0.
- Snapshot with backpressure, NUM_CH=4, counts {5,6,7,3}: snap_in while ch0 events continue; ready toggles 1,0,1,1,0,1 → words (0,5),(1,6),(2,7),(3,3) in order; data stable during stalls; busy falls after the 4th handshake.
- Overrun: snap_in during STREAM → stream unchanged, snap_overrun_out=1. clr_in → 0. clr_in with a simultaneous snap_in while busy → stays 1.
- Async reset mid-stream at index 2: rst_n_in low between clock edges → immediate valid=0, busy=0, counts 0. After release, a new snap_in streams from index 0.
